// File: rtl/vend_pkg.sv
// Shared types and coin helpers for the multi-product vending controller.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        VEND,
        CHANGE,
        REFUND
    } state_t;

    localparam logic [1:0] HALF_UNITS = 2'd1;
    localparam logic [1:0] ONE_UNITS  = 2'd2;

    // Simultaneous coins are worth nothing; the controller rejects both.
    function automatic logic [1:0] coin_value(input logic half, input logic one);
        logic [1:0] v;
        v = 2'd0;
        if (half && !one)
            v = HALF_UNITS;
        else if (one && !half)
            v = ONE_UNITS;
        return v;
    endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-item stock counters with reset/restock reload and a single decrement port.
module vend_stock_bank
    import vend_pkg::*;
#(
    parameter int N_ITEMS    = 4,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 8,
    parameter int SEL_W      = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_restock,
    input  logic [SEL_W-1:0]   i_restock_item,
    input  logic               i_dec,
    input  logic [SEL_W-1:0]   i_dec_item,
    output logic [N_ITEMS-1:0] o_sold_out
);

    logic [STOCK_W-1:0] r_stock [N_ITEMS];

    // Restock outranks a same-cycle decrement of the same item.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < N_ITEMS; i++) begin
            if (i_rst)
                r_stock[i] <= STOCK_W'(STOCK_INIT);
            else if (i_restock && (int'(i_restock_item) == i))
                r_stock[i] <= STOCK_W'(STOCK_INIT);
            else if (i_dec && (int'(i_dec_item) == i) && (r_stock[i] != '0))
                r_stock[i] <= r_stock[i] - STOCK_W'(1);
        end
    end

    always_comb begin
        o_sold_out = '0;
        for (int i = 0; i < N_ITEMS; i++)
            o_sold_out[i] = (r_stock[i] == '0);
    end

endmodule

// File: rtl/vending_ctrl_multi.sv
// Multi-product coin vending controller: credit, selection, vend and half-dollar change train.
//   state  | meaning
//   IDLE   | no credit held
//   ACCUM  | credit > 0, accepting coins / selection / cancel
//   VEND   | one-cycle product release, price deducted
//   CHANGE | paying remaining credit after a vend
//   REFUND | paying back all credit after cancel
module vending_ctrl_multi
    import vend_pkg::*;
#(
    parameter int N_ITEMS     = 4,
    parameter int PRICE_UNITS = 4,
    parameter int MAX_CREDIT  = 8,
    parameter int CREDIT_W    = 4,
    parameter int STOCK_W     = 4,
    parameter int STOCK_INIT  = 8,
    parameter int SEL_W       = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_half_dollar,
    input  logic                i_one_dollar,
    input  logic                i_sel_valid,
    input  logic [SEL_W-1:0]    i_sel_item,
    input  logic                i_cancel,
    input  logic                i_restock,
    input  logic [SEL_W-1:0]    i_restock_item,
    output logic                o_dispense,
    output logic [SEL_W-1:0]    o_dispense_item,
    output logic                o_collect,
    output logic                o_change_out,
    output logic                o_coin_reject,
    output logic                o_sel_err,
    output logic [CREDIT_W-1:0] o_credit,
    output logic                o_busy,
    output logic [N_ITEMS-1:0]  o_sold_out
);

    state_t              r_state, w_state_nxt;
    logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
    logic [SEL_W-1:0]    r_dispense_item, w_dispense_item_nxt;
    logic                r_dispense, w_dispense_nxt;
    logic                r_collect, w_collect_nxt;
    logic                r_change_out, w_change_out_nxt;
    logic                r_coin_reject, w_coin_reject_nxt;
    logic                r_sel_err, w_sel_err_nxt;
    logic                w_dec;
    logic [N_ITEMS-1:0]  w_sold_out;
    logic                w_coin_any, w_coin_both, w_coin_fits, w_sel_ok;
    logic [1:0]          w_coin_val;
    logic [CREDIT_W:0]   w_credit_sum;
    logic [CREDIT_W-1:0] w_remain;

    assign w_coin_any   = i_half_dollar | i_one_dollar;
    assign w_coin_both  = i_half_dollar & i_one_dollar;
    assign w_coin_val   = coin_value(i_half_dollar, i_one_dollar);
    assign w_credit_sum = {1'b0, r_credit} + (CREDIT_W+1)'(w_coin_val);
    assign w_coin_fits  = !w_coin_both && (w_credit_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    assign w_remain     = r_credit - CREDIT_W'(PRICE_UNITS);

    always_comb begin
        w_sel_ok = 1'b0;
        if (int'(i_sel_item) < N_ITEMS)
            w_sel_ok = (r_credit >= CREDIT_W'(PRICE_UNITS)) && !w_sold_out[i_sel_item];
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_credit_nxt        = r_credit;
        w_dispense_item_nxt = '0;
        w_dispense_nxt      = 1'b0;
        w_collect_nxt       = 1'b0;
        w_change_out_nxt    = 1'b0;
        w_coin_reject_nxt   = 1'b0;
        w_sel_err_nxt       = 1'b0;
        w_dec               = 1'b0;
        case (r_state)
            IDLE, ACCUM: begin
                if (i_cancel && (r_state == ACCUM)) begin
                    w_state_nxt       = REFUND;
                    w_coin_reject_nxt = w_coin_any;
                end else if (i_sel_valid && (r_state == ACCUM) && w_sel_ok) begin
                    w_state_nxt         = VEND;
                    w_dispense_nxt      = 1'b1;
                    w_collect_nxt       = 1'b1;
                    w_dispense_item_nxt = i_sel_item;
                    w_coin_reject_nxt   = w_coin_any;
                end else begin
                    // A refused selection does not block a coin in the same cycle.
                    w_sel_err_nxt = i_sel_valid;
                    if (w_coin_any) begin
                        if (w_coin_fits) begin
                            w_credit_nxt = w_credit_sum[CREDIT_W-1:0];
                            w_state_nxt  = ACCUM;
                        end else begin
                            w_coin_reject_nxt = 1'b1;
                        end
                    end
                end
            end
            VEND: begin
                w_dec             = 1'b1;
                w_credit_nxt      = w_remain;
                w_coin_reject_nxt = w_coin_any;
                w_state_nxt       = (w_remain != '0) ? CHANGE : IDLE;
            end
            CHANGE, REFUND: begin
                w_coin_reject_nxt = w_coin_any;
                if (r_credit != '0) begin
                    w_change_out_nxt = 1'b1;
                    w_credit_nxt     = r_credit - CREDIT_W'(1);
                end
                if (r_credit <= CREDIT_W'(1))
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= IDLE;
            r_credit        <= '0;
            r_dispense_item <= '0;
            r_dispense      <= 1'b0;
            r_collect       <= 1'b0;
            r_change_out    <= 1'b0;
            r_coin_reject   <= 1'b0;
            r_sel_err       <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_credit        <= w_credit_nxt;
            r_dispense_item <= w_dispense_item_nxt;
            r_dispense      <= w_dispense_nxt;
            r_collect       <= w_collect_nxt;
            r_change_out    <= w_change_out_nxt;
            r_coin_reject   <= w_coin_reject_nxt;
            r_sel_err       <= w_sel_err_nxt;
        end
    end

    vend_stock_bank #(
        .N_ITEMS    (N_ITEMS),
        .STOCK_W    (STOCK_W),
        .STOCK_INIT (STOCK_INIT),
        .SEL_W      (SEL_W)
    ) u_stock (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_restock      (i_restock),
        .i_restock_item (i_restock_item),
        .i_dec          (w_dec),
        .i_dec_item     (r_dispense_item),
        .o_sold_out     (w_sold_out)
    );

    assign o_dispense      = r_dispense;
    assign o_dispense_item = r_dispense_item;
    assign o_collect       = r_collect;
    assign o_change_out    = r_change_out;
    assign o_coin_reject   = r_coin_reject;
    assign o_sel_err       = r_sel_err;
    assign o_credit        = r_credit;
    assign o_busy          = (r_state == VEND) || (r_state == CHANGE) || (r_state == REFUND);
    assign o_sold_out      = w_sold_out;

endmodule
